// File: rtl/sdrc_arb_pkg.sv
// sdrc_arb_pkg: shared types and width helpers for the SDRAM application-port arbiter.
//   arb_state_t : arbiter transaction phase (IDLE, REQ, WR, RD)
//   idx_w       : bits needed to index n requesters
//   slice_w     : width of a bus packing n fields of w bits
package sdrc_arb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WR, RD} arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_w(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/sdrc_rr_picker.sv
// sdrc_rr_picker: combinational round-robin select.
//   req : request vector
//   ptr : index of the last owner; the search starts at ptr+1 (mod N)
//   gnt : one-hot winner (0 when nothing requests)
//   idx : binary index of the winner
//   any : at least one request is present
module sdrc_rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int best;
    int d;

    // d is the distance of requester j past ptr; the smallest distance wins
    always_comb begin
        gnt  = '0;
        idx  = '0;
        best = N;
        d    = 0;
        for (int j = 0; j < N; j++) begin
            d = (j + 2 * N - int'(ptr) - 1) % N;
            if (req[j] && d < best) begin
                best   = d;
                idx    = IW'(j);
                gnt    = '0;
                gnt[j] = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/sdrc_app_arbiter.sv
// sdrc_app_arbiter: round-robin sharing of the SDRAM controller application port.
// One whole transaction (request, ack, full write or read burst) is owned by
// one requester at a time; the next grant is picked in IDLE.
// Requester side : m_req/m_req_addr/m_req_len/m_req_wr_n/m_wr_data/m_wr_en_n in,
//                  m_req_ack/m_grant/m_wr_next/m_rd_valid/m_last_rd/m_last_wr/m_rd_data out
// Controller side: app_req/app_req_addr/app_req_len/app_req_wr_n/app_wr_data/app_wr_en_n out,
//                  app_req_ack/app_busy_n/app_wr_next_req/app_rd_valid/app_last_rd/
//                  app_last_wr/app_rd_data in
// arb_wdog_err   : one-cycle pulse when a stalled transaction is abandoned
// Optional macro SDRC_ARB_WDOG_EN enables the stall watchdog (WDOG_CYC cycles).
module sdrc_app_arbiter
    import sdrc_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int APP_AW   = 26,
    parameter int dw       = 32,
    parameter int bl       = 9,
    parameter int WDOG_CYC = 1024
) (
    input  logic                                sdram_clk,
    input  logic                                sdram_resetn,
    input  logic [NUM_REQ-1:0]                  m_req,
    input  logic [slice_w(NUM_REQ, APP_AW)-1:0] m_req_addr,
    input  logic [slice_w(NUM_REQ, bl)-1:0]     m_req_len,
    input  logic [NUM_REQ-1:0]                  m_req_wr_n,
    input  logic [slice_w(NUM_REQ, dw)-1:0]     m_wr_data,
    input  logic [slice_w(NUM_REQ, dw/8)-1:0]   m_wr_en_n,
    output logic [NUM_REQ-1:0]                  m_req_ack,
    output logic [NUM_REQ-1:0]                  m_grant,
    output logic [NUM_REQ-1:0]                  m_wr_next,
    output logic [NUM_REQ-1:0]                  m_rd_valid,
    output logic [NUM_REQ-1:0]                  m_last_rd,
    output logic [NUM_REQ-1:0]                  m_last_wr,
    output logic [dw-1:0]                       m_rd_data,
    output logic                                app_req,
    output logic [APP_AW-1:0]                   app_req_addr,
    output logic [bl-1:0]                       app_req_len,
    output logic                                app_req_wr_n,
    output logic [dw-1:0]                       app_wr_data,
    output logic [dw/8-1:0]                     app_wr_en_n,
    input  logic                                app_req_ack,
    input  logic                                app_busy_n,
    input  logic                                app_wr_next_req,
    input  logic                                app_rd_valid,
    input  logic                                app_last_rd,
    input  logic                                app_last_wr,
    input  logic [dw-1:0]                       app_rd_data,
    output logic                                arb_wdog_err
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int BW = dw / 8;

    arb_state_t         state, state_nx;
    logic [IW-1:0]      rr_ptr, gidx, pidx;
    logic [NUM_REQ-1:0] pgnt;
    logic               pany, take, done, wdog, wsel;

    sdrc_rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req (m_req),
        .ptr (rr_ptr),
        .gnt (pgnt),
        .idx (pidx),
        .any (pany)
    );

`ifdef SDRC_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wcnt;
    logic          wdog_q;
    logic          alive;

    // any controller handshake proves the transaction is still progressing
    assign alive = app_req_ack | app_wr_next_req | app_rd_valid;
    assign wdog  = (state != IDLE) && !alive && (wcnt == WW'(WDOG_CYC - 1));

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            wcnt   <= '0;
            wdog_q <= 1'b0;
        end else begin
            wcnt   <= (state == IDLE || alive) ? '0 : wcnt + 1'b1;
            wdog_q <= wdog;
        end
    end

    assign arb_wdog_err = wdog_q;
`else
    logic unused_wdog;
    assign unused_wdog  = WDOG_CYC > 0;
    assign wdog         = 1'b0;
    assign arb_wdog_err = 1'b0;
`endif

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) state <= IDLE;
        else               state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (app_busy_n && pany) begin
                state_nx = REQ;
                take     = 1'b1;
            end
            REQ:  if (app_req_ack) state_nx = app_req_wr_n ? RD : WR;
            WR:   if (app_wr_next_req && app_last_wr) begin
                state_nx = IDLE;
                done     = 1'b1;
            end
            RD:   if (app_rd_valid && app_last_rd) begin
                state_nx = IDLE;
                done     = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (wdog) begin
            state_nx = IDLE;
            done     = 1'b1;
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            rr_ptr       <= '0;
            gidx         <= '0;
            m_grant      <= '0;
            app_req      <= 1'b0;
            app_req_addr <= '0;
            app_req_len  <= '0;
            app_req_wr_n <= 1'b1;
        end else begin
            if (take) begin
                m_grant      <= pgnt;
                gidx         <= pidx;
                app_req      <= 1'b1;
                app_req_addr <= m_req_addr[pidx*APP_AW +: APP_AW];
                app_req_len  <= m_req_len[pidx*bl +: bl];
                app_req_wr_n <= m_req_wr_n[pidx];
            end
            if (state == REQ && app_req_ack) app_req <= 1'b0;
            if (done) begin
                rr_ptr  <= gidx;
                m_grant <= '0;
                app_req <= 1'b0;
            end
        end
    end

    // m_grant is non-zero only while a transaction is in flight, so it gates routing
    assign wsel        = (state == REQ) || (state == WR);
    assign app_wr_data = wsel ? m_wr_data[gidx*dw +: dw] : '0;
    assign app_wr_en_n = wsel ? m_wr_en_n[gidx*BW +: BW] : '1;
    assign m_req_ack   = (state == REQ && app_req_ack) ? m_grant : '0;
    assign m_wr_next   = app_wr_next_req ? m_grant : '0;
    assign m_rd_valid  = app_rd_valid    ? m_grant : '0;
    assign m_last_rd   = app_last_rd     ? m_grant : '0;
    assign m_last_wr   = app_last_wr     ? m_grant : '0;
    assign m_rd_data   = app_rd_data;

endmodule

// File: tb/tb_sdrc_app_arbiter.sv
// tb_sdrc_app_arbiter: self-checking bench for sdrc_app_arbiter (NUM_REQ=2).
module tb_sdrc_app_arbiter;

    localparam int NR = 2;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int BL = 9;
    localparam int BW = DW / 8;

    logic              sdram_clk = 1'b0;
    logic              sdram_resetn;
    logic [NR-1:0]     m_req;
    logic [NR*AW-1:0]  m_req_addr;
    logic [NR*BL-1:0]  m_req_len;
    logic [NR-1:0]     m_req_wr_n;
    logic [NR*DW-1:0]  m_wr_data;
    logic [NR*BW-1:0]  m_wr_en_n;
    logic [NR-1:0]     m_req_ack, m_grant, m_wr_next, m_rd_valid, m_last_rd, m_last_wr;
    logic [DW-1:0]     m_rd_data;
    logic              app_req;
    logic [AW-1:0]     app_req_addr;
    logic [BL-1:0]     app_req_len;
    logic              app_req_wr_n;
    logic [DW-1:0]     app_wr_data;
    logic [BW-1:0]     app_wr_en_n;
    logic              app_req_ack, app_busy_n, app_wr_next_req, app_rd_valid, app_last_rd, app_last_wr;
    logic [DW-1:0]     app_rd_data;
    logic              arb_wdog_err;

    int checks = 0;
    int errors = 0;

    sdrc_app_arbiter #(.NUM_REQ(NR), .APP_AW(AW), .dw(DW), .bl(BL), .WDOG_CYC(16)) dut (
        .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn),
        .m_req(m_req), .m_req_addr(m_req_addr), .m_req_len(m_req_len), .m_req_wr_n(m_req_wr_n),
        .m_wr_data(m_wr_data), .m_wr_en_n(m_wr_en_n),
        .m_req_ack(m_req_ack), .m_grant(m_grant), .m_wr_next(m_wr_next), .m_rd_valid(m_rd_valid),
        .m_last_rd(m_last_rd), .m_last_wr(m_last_wr), .m_rd_data(m_rd_data),
        .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
        .app_req_ack(app_req_ack), .app_busy_n(app_busy_n), .app_wr_next_req(app_wr_next_req),
        .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd), .app_last_wr(app_last_wr),
        .app_rd_data(app_rd_data), .arb_wdog_err(arb_wdog_err)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct {
        logic [1:0] req;
        logic       busy_n, ack, wnx, lwr;
        logic       e_req;
        logic [1:0] e_gnt, e_ack, e_wnx, e_lwr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic [1:0] req, input logic busy_n, input logic ack,
                               input logic wnx, input logic lwr, input logic e_req,
                               input logic [1:0] e_gnt, input logic [1:0] e_ack,
                               input logic [1:0] e_wnx, input logic [1:0] e_lwr);
        vec_t r;
        r.req = req; r.busy_n = busy_n; r.ack = ack; r.wnx = wnx; r.lwr = lwr;
        r.e_req = e_req; r.e_gnt = e_gnt; r.e_ack = e_ack; r.e_wnx = e_wnx; r.e_lwr = e_lwr;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic app_quiet;
        app_req_ack = 1'b0; app_wr_next_req = 1'b0; app_last_wr = 1'b0;
        app_rd_valid = 1'b0; app_last_rd = 1'b0;
    endtask

    task automatic set_m(input int i, input logic [AW-1:0] a, input logic [BL-1:0] l,
                         input logic wrn, input logic [DW-1:0] d, input logic [BW-1:0] en);
        m_req_addr[i*AW +: AW] = a;
        m_req_len[i*BL +: BL]  = l;
        m_req_wr_n[i]          = wrn;
        m_wr_data[i*DW +: DW]  = d;
        m_wr_en_n[i*BW +: BW]  = en;
    endtask

    int          ph, own, last, ack_wait, left, drop, n;
    logic [AW-1:0] e_addr;
    logic [BL-1:0] e_len;
    logic          e_wrn, wsel;
    logic [1:0]    gexp;
    logic [DW-1:0] d;

    initial begin
        sdram_resetn = 1'b0;
        m_req = '0; m_req_addr = '0; m_req_len = '0; m_req_wr_n = '0; m_wr_data = '0; m_wr_en_n = '1;
        app_busy_n = 1'b1; app_rd_data = '0;
        app_quiet();
        repeat (3) @(posedge sdram_clk);
        #1;
        chk("rst_app_req", 64'(app_req), 64'(0));
        chk("rst_grant", 64'(m_grant), 64'(0));
        chk("rst_addr", 64'(app_req_addr), 64'(0));
        chk("rst_len", 64'(app_req_len), 64'(0));
        chk("rst_wr_n", 64'(app_req_wr_n), 64'(1));
        chk("rst_wr_en_n", 64'(app_wr_en_n), 64'(4'hF));
        chk("rst_wr_data", 64'(app_wr_data), 64'(0));
        chk("rst_wdog", 64'(arb_wdog_err), 64'(0));
        sdram_resetn = 1'b1;
        cyc();

        // single write then busy gating, requester 0: addr 0x100, len 4, write
        set_m(0, 26'h100, 9'd4, 1'b0, 32'hA5A5_0001, 4'h3);
        vt.push_back(v(2'b01,1,0,0,0, 0,2'b00,2'b00,2'b00,2'b00));
        vt.push_back(v(2'b01,1,0,0,0, 1,2'b01,2'b00,2'b00,2'b00));
        vt.push_back(v(2'b01,1,0,0,0, 1,2'b01,2'b00,2'b00,2'b00));
        vt.push_back(v(2'b01,1,1,0,0, 1,2'b01,2'b01,2'b00,2'b00));
        vt.push_back(v(2'b00,1,0,1,0, 0,2'b01,2'b00,2'b01,2'b00));
        vt.push_back(v(2'b00,1,0,1,0, 0,2'b01,2'b00,2'b01,2'b00));
        vt.push_back(v(2'b00,1,0,0,0, 0,2'b01,2'b00,2'b00,2'b00));
        vt.push_back(v(2'b00,1,0,1,0, 0,2'b01,2'b00,2'b01,2'b00));
        vt.push_back(v(2'b00,1,0,1,1, 0,2'b01,2'b00,2'b01,2'b01));
        vt.push_back(v(2'b00,1,0,0,0, 0,2'b00,2'b00,2'b00,2'b00));
        vt.push_back(v(2'b01,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b00));
        vt.push_back(v(2'b01,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b00));
        vt.push_back(v(2'b01,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b00));
        vt.push_back(v(2'b01,1,0,0,0, 0,2'b00,2'b00,2'b00,2'b00));
        vt.push_back(v(2'b01,1,0,0,0, 1,2'b01,2'b00,2'b00,2'b00));
        vt.push_back(v(2'b01,1,1,0,0, 1,2'b01,2'b01,2'b00,2'b00));
        vt.push_back(v(2'b00,1,0,1,0, 0,2'b01,2'b00,2'b01,2'b00));
        vt.push_back(v(2'b00,1,0,1,0, 0,2'b01,2'b00,2'b01,2'b00));
        vt.push_back(v(2'b00,1,0,1,0, 0,2'b01,2'b00,2'b01,2'b00));
        vt.push_back(v(2'b00,1,0,1,1, 0,2'b01,2'b00,2'b01,2'b01));
        vt.push_back(v(2'b00,1,0,0,0, 0,2'b00,2'b00,2'b00,2'b00));
        for (int i = 0; i < vt.size(); i++) begin
            m_req = vt[i].req; app_busy_n = vt[i].busy_n; app_req_ack = vt[i].ack;
            app_wr_next_req = vt[i].wnx; app_last_wr = vt[i].lwr;
            #2;
            chk($sformatf("vec%0d_app_req", i), 64'(app_req), 64'(vt[i].e_req));
            chk($sformatf("vec%0d_grant", i), 64'(m_grant), 64'(vt[i].e_gnt));
            chk($sformatf("vec%0d_ack", i), 64'(m_req_ack), 64'(vt[i].e_ack));
            chk($sformatf("vec%0d_wr_next", i), 64'(m_wr_next), 64'(vt[i].e_wnx));
            chk($sformatf("vec%0d_last_wr", i), 64'(m_last_wr), 64'(vt[i].e_lwr));
            chk($sformatf("vec%0d_rd_valid", i), 64'(m_rd_valid), 64'(0));
            if (vt[i].e_req) begin
                chk($sformatf("vec%0d_addr", i), 64'(app_req_addr), 64'(26'h100));
                chk($sformatf("vec%0d_len", i), 64'(app_req_len), 64'(4));
                chk($sformatf("vec%0d_wr_n", i), 64'(app_req_wr_n), 64'(0));
            end
            if (vt[i].e_gnt != 2'b00) begin
                chk($sformatf("vec%0d_wr_data", i), 64'(app_wr_data), 64'(32'hA5A5_0001));
                chk($sformatf("vec%0d_wr_en_n", i), 64'(app_wr_en_n), 64'(4'h3));
            end
            cyc();
        end
        app_quiet();

        // read routing: requester 1 reads 8 beats
        set_m(1, 26'h200, 9'd8, 1'b1, 32'h0, 4'hF);
        m_req = 2'b10;
        #2;
        chk("rd_idle_app_req", 64'(app_req), 64'(0));
        cyc();
        app_req_ack = 1'b1;
        #2;
        chk("rd_app_req", 64'(app_req), 64'(1));
        chk("rd_grant", 64'(m_grant), 64'(2'b10));
        chk("rd_addr", 64'(app_req_addr), 64'(26'h200));
        chk("rd_len", 64'(app_req_len), 64'(8));
        chk("rd_wr_n", 64'(app_req_wr_n), 64'(1));
        chk("rd_ack", 64'(m_req_ack), 64'(2'b10));
        cyc();
        m_req = 2'b00; app_req_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            app_rd_valid = 1'b1; app_rd_data = d; app_last_rd = (k == 7);
            #2;
            chk($sformatf("rd%0d_valid", k), 64'(m_rd_valid), 64'(2'b10));
            chk($sformatf("rd%0d_data", k), 64'(m_rd_data), 64'(d));
            chk($sformatf("rd%0d_last", k), 64'(m_last_rd), 64'((k == 7) ? 2'b10 : 2'b00));
            chk($sformatf("rd%0d_app_req", k), 64'(app_req), 64'(0));
            cyc();
        end
        app_quiet();
        #2;
        chk("rd_release", 64'(m_grant), 64'(0));

        // fairness: both hold requests, grants alternate starting after last owner 1
        set_m(0, 26'h10, 9'd1, 1'b1, 32'h0, 4'hF);
        set_m(1, 26'h11, 9'd1, 1'b1, 32'h0, 4'hF);
        m_req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            #2;
            chk($sformatf("fair%0d_idle", t), 64'(m_grant), 64'(0));
            cyc();
            app_req_ack = 1'b1;
            #2;
            chk($sformatf("fair%0d_grant", t), 64'(m_grant), 64'((t % 2 == 0) ? 2'b01 : 2'b10));
            chk($sformatf("fair%0d_addr", t), 64'(app_req_addr), 64'((t % 2 == 0) ? 26'h10 : 26'h11));
            cyc();
            app_req_ack = 1'b0; app_rd_valid = 1'b1; app_last_rd = 1'b1;
            cyc();
            app_quiet();
        end
        m_req = 2'b00;
        cyc();

`ifdef SDRC_ARB_WDOG_EN
        // watchdog: ack never arrives
        set_m(0, 26'h300, 9'd4, 1'b0, 32'h0, 4'h0);
        m_req = 2'b01;
        cyc();
        m_req = 2'b00;
        #2;
        chk("wdog_app_req_up", 64'(app_req), 64'(1));
        n = 40;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            #2;
            if (arb_wdog_err) begin
                n = k;
                break;
            end
        end
        chk("wdog_cycle", 64'(n), 64'(16));
        chk("wdog_app_req_drop", 64'(app_req), 64'(0));
        chk("wdog_grant_drop", 64'(m_grant), 64'(0));
        cyc();
        #2;
        chk("wdog_pulse_end", 64'(arb_wdog_err), 64'(0));
        cyc();
`endif

        // reset mid-burst after 2 of 4 write beats
        set_m(0, 26'h100, 9'd4, 1'b0, 32'h1234_5678, 4'h5);
        m_req = 2'b01;
        cyc();
        app_req_ack = 1'b1;
        cyc();
        m_req = 2'b00; app_req_ack = 1'b0; app_wr_next_req = 1'b1;
        cyc();
        cyc();
        app_wr_next_req = 1'b0;
        #2;
        chk("mid_grant", 64'(m_grant), 64'(2'b01));
        chk("mid_wr_en_n", 64'(app_wr_en_n), 64'(4'h5));
        sdram_resetn = 1'b0;
        #1;
        chk("mid_rst_app_req", 64'(app_req), 64'(0));
        chk("mid_rst_grant", 64'(m_grant), 64'(0));
        chk("mid_rst_wr_en_n", 64'(app_wr_en_n), 64'(4'hF));
        chk("mid_rst_wr_data", 64'(app_wr_data), 64'(0));
        cyc();
        sdram_resetn = 1'b1;
        set_m(1, 26'h222, 9'd1, 1'b1, 32'h0, 4'hF);
        m_req = 2'b11;
        #2;
        chk("post_rst_idle", 64'(app_req), 64'(0));
        cyc();
        app_req_ack = 1'b1;
        #2;
        chk("post_rst_grant", 64'(m_grant), 64'(2'b10));
        chk("post_rst_addr", 64'(app_req_addr), 64'(26'h222));
        cyc();
        m_req = 2'b00; app_req_ack = 1'b0; app_rd_valid = 1'b1; app_last_rd = 1'b1;
        cyc();
        app_quiet();

        // randomized traffic against a transaction-level model
        ph = 0; last = 1; own = 0; ack_wait = 0; left = 0; drop = -1;
        e_addr = '0; e_len = '0; e_wrn = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (drop >= 0) m_req[drop] = 1'b0;
            drop = -1;
            for (int i = 0; i < NR; i++)
                if (!m_req[i] && $urandom_range(3) == 0) begin
                    set_m(i, AW'($urandom), BL'($urandom_range(6, 1)), 1'($urandom_range(1)),
                          $urandom, BW'($urandom));
                    m_req[i] = 1'b1;
                end
            app_busy_n = ($urandom_range(7) != 0);
            app_quiet();
            if (ph == 1 && ack_wait == 0) app_req_ack = 1'b1;
            if (ph == 2 && $urandom_range(2) != 0) begin
                if (!e_wrn) begin
                    app_wr_next_req = 1'b1; app_last_wr = (left == 1);
                end else begin
                    app_rd_valid = 1'b1; app_last_rd = (left == 1); app_rd_data = $urandom;
                end
            end
            #2;
            gexp = (ph != 0) ? 2'(1 << own) : 2'b00;
            wsel = (ph == 1) || (ph == 2 && !e_wrn);
            chk("rnd_app_req", 64'(app_req), 64'(ph == 1));
            chk("rnd_grant", 64'(m_grant), 64'(gexp));
            chk("rnd_ack", 64'(m_req_ack), 64'(app_req_ack ? gexp : 2'b00));
            chk("rnd_wr_next", 64'(m_wr_next), 64'(app_wr_next_req ? gexp : 2'b00));
            chk("rnd_last_wr", 64'(m_last_wr), 64'(app_last_wr ? gexp : 2'b00));
            chk("rnd_rd_valid", 64'(m_rd_valid), 64'(app_rd_valid ? gexp : 2'b00));
            chk("rnd_last_rd", 64'(m_last_rd), 64'(app_last_rd ? gexp : 2'b00));
            chk("rnd_rd_data", 64'(m_rd_data), 64'(app_rd_data));
            chk("rnd_wr_data", 64'(app_wr_data), 64'(wsel ? m_wr_data[own*DW +: DW] : 32'h0));
            chk("rnd_wr_en_n", 64'(app_wr_en_n), 64'(wsel ? m_wr_en_n[own*BW +: BW] : 4'hF));
            if (ph == 1) begin
                chk("rnd_addr", 64'(app_req_addr), 64'(e_addr));
                chk("rnd_len", 64'(app_req_len), 64'(e_len));
                chk("rnd_wr_n", 64'(app_req_wr_n), 64'(e_wrn));
            end
            if (ph == 0) begin
                if (app_busy_n && m_req != '0) begin
                    for (int k = NR; k >= 1; k--)
                        if (m_req[(last + k) % NR]) own = (last + k) % NR;
                    e_addr = m_req_addr[own*AW +: AW];
                    e_len = m_req_len[own*BL +: BL];
                    e_wrn = m_req_wr_n[own];
                    ack_wait = $urandom_range(3);
                    ph = 1;
                end
            end else if (ph == 1) begin
                if (app_req_ack) begin
                    ph = 2; left = int'(e_len); drop = own;
                end else ack_wait--;
            end else if (app_wr_next_req || app_rd_valid) begin
                left--;
                if (left == 0) begin
                    ph = 0; last = own;
                end
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
